// File: rtl/spi_stim_pkg.sv
// Shared types and constants for the SPI target-side pattern responder.
// Holds the pattern/FSM enums and the 16-bit Fibonacci LFSR definition.
package spi_stim_pkg;

    typedef enum logic [1:0] {
        PM_TOGGLE = 2'd0,
        PM_COUNT  = 2'd1,
        PM_LFSR   = 2'd2,
        PM_ECHO   = 2'd3
    } pattern_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam int ADDR_W = 24;
    localparam int LFSR_W = 16;

    // Taps for x^16+x^14+x^13+x^11, expressed on a right-shifting register
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'h002D;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {^(cur & LFSR_TAPS), cur[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Purpose: 2-flop synchronisers for SCK/CS_n/MOSI plus SCK and CS edge detection.
// Latency: pin change visible as an edge strobe 2 core_clk cycles later.
// Backpressure: none; free-running sampler.
module spi_pin_sync (
    input  logic core_clk,
    input  logic rst_n,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic mosi_s
);

    logic [1:0] sck_sy;
    logic [1:0] cs_sy;
    logic [1:0] mosi_sy;
    logic       sck_d;
    logic       cs_d;

    // CS chain resets low so a select already held low across reset never
    // looks like a fresh falling edge; a frame needs a real high-to-low.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sy  <= '0;
            cs_sy   <= '0;
            mosi_sy <= '0;
            sck_d   <= 1'b0;
            cs_d    <= 1'b0;
        end else begin
            sck_sy  <= {sck_sy[0], sck};
            cs_sy   <= {cs_sy[0], cs_n};
            mosi_sy <= {mosi_sy[0], mosi};
            sck_d   <= sck_sy[1];
            cs_d    <= cs_sy[1];
        end
    end

    assign sck_rise = sck_sy[1] & ~sck_d;
    assign sck_fall = ~sck_sy[1] & sck_d;
    assign cs_rise  = cs_sy[1] & ~cs_d;
    assign cs_fall  = ~cs_sy[1] & cs_d;
    assign mosi_s   = mosi_sy[1];

endmodule

// File: rtl/spi_miso_pattern_gen.sv
// Purpose: SPI mode-0 target capturing cmd/addr header, driving MISO from a selectable pattern (MISO_HIZ_EN adds spi_miso_oe).
// Latency: 3 CLKA cycles from pin edge to action (MOSI capture, MISO update, strobes).
// Backpressure: none; SCK must be at most CLKA/4, edges while CS is high are ignored.
module spi_miso_pattern_gen
    import spi_stim_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                CMD_BYTES = 4,
    parameter int                CNT_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic              CLKA,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
`ifdef MISO_HIZ_EN
    output logic              spi_miso_oe,
`endif
    output logic              spi_miso,
    input  logic [1:0]        pattern_mode,
    output logic [DATA_W-1:0] cmd_byte,
    output logic [ADDR_W-1:0] addr,
    output logic              cmd_valid,
    output logic [CNT_W-1:0]  byte_count,
    output logic              busy,
    output logic              frame_err
);

    localparam int                BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CMD_CNT  = CNT_W'(CMD_BYTES);
    localparam logic [CNT_W-1:0]  CMD_LAST = CNT_W'(CMD_BYTES - 1);

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;

    spi_pin_sync u_sync (
        .core_clk (CLKA),
        .rst_n    (rst_n),
        .sck      (spi_clk),
        .cs_n     (spi_cs_n),
        .mosi     (spi_mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall),
        .mosi_s   (mosi_s)
    );

    state_e              state_q, state_d;
    pattern_mode_e       mode_q;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-2:0]   rx_sh;
    logic [DATA_W-1:0]   rx_next;
    logic [DATA_W-1:0]   echo_q;
    logic [LFSR_W-1:0]   lfsr_q;
    logic                toggle_q;
    logic                miso_q;
    logic                bit_last;
    logic                hdr_done;
    logic [BIT_W-1:0]    bit_sel;
    logic [DATA_W-1:0]   cnt_byte;

    assign rx_next  = {rx_sh, mosi_s};
    assign bit_last = (bit_cnt == BIT_LAST);
    assign hdr_done = sck_rise && bit_last && (byte_count == CMD_LAST);
    assign bit_sel  = BIT_LAST - bit_cnt;
    // Data byte index; only meaningful in DATA, where byte_count >= CMD_BYTES
    assign cnt_byte = DATA_W'(byte_count - CMD_CNT);

    always_ff @(posedge CLKA or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cs_fall) state_d = HDR;
            HDR: begin
                if (cs_rise)       state_d = IDLE;
                else if (hdr_done) state_d = DATA;
            end
            DATA: if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLKA or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= PM_TOGGLE;
            bit_cnt    <= '0;
            rx_sh      <= '0;
            echo_q     <= '0;
            lfsr_q     <= LFSR_SEED;
            toggle_q   <= 1'b0;
            miso_q     <= 1'b0;
            cmd_byte   <= '0;
            addr       <= '0;
            cmd_valid  <= 1'b0;
            byte_count <= '0;
            frame_err  <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            if (state_q == IDLE) begin
                if (cs_fall) begin
                    mode_q     <= pattern_mode_e'(pattern_mode);
                    bit_cnt    <= '0;
                    byte_count <= '0;
                    lfsr_q     <= LFSR_SEED;
                    miso_q     <= (pattern_mode_e'(pattern_mode) == PM_TOGGLE) ? toggle_q : 1'b0;
                end
            end else if (cs_rise) begin
                frame_err <= (bit_cnt != '0);
            end else begin
                if (sck_rise) begin
                    rx_sh   <= rx_next[DATA_W-2:0];
                    bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
                    if (bit_last) begin
                        echo_q <= rx_next;
                        if (byte_count != '1) byte_count <= byte_count + 1'b1;
                        if (state_q == HDR) begin
                            if (byte_count == '0) cmd_byte <= rx_next;
                            else                  addr <= {addr[ADDR_W-DATA_W-1:0], rx_next};
                            if (byte_count == CMD_LAST) cmd_valid <= 1'b1;
                        end
                    end
                end
                // bit_cnt already points at the bit the next rising edge samples
                if (sck_fall) begin
                    case (mode_q)
                        PM_TOGGLE: begin
                            toggle_q <= ~toggle_q;
                            miso_q   <= ~toggle_q;
                        end
                        PM_COUNT: miso_q <= (state_q == DATA) ? cnt_byte[bit_sel] : 1'b0;
                        PM_LFSR: begin
                            if (state_q == DATA) begin
                                miso_q <= lfsr_q[0];
                                lfsr_q <= lfsr_step(lfsr_q);
                            end else begin
                                miso_q <= 1'b0;
                            end
                        end
                        PM_ECHO: miso_q <= (state_q == DATA) ? echo_q[bit_sel] : 1'b0;
                        default: miso_q <= 1'b0;
                    endcase
                end
            end
        end
    end

    assign busy = (state_q != IDLE);

`ifdef MISO_HIZ_EN
    assign spi_miso_oe = busy;
    assign spi_miso    = miso_q & busy;
`else
    assign spi_miso    = miso_q;
`endif

endmodule

// File: doc/spi_miso_pattern_gen.md
Name: spi_miso_pattern_gen

Overview:
Synthesisable SPI target-side responder that replaces the fixed "toggle MISO on every SCK fall" stimulus with a parametrised pattern source. It oversamples SPI_CLK/SPI_CS_n/SPI_MOSI in the system clock domain, captures the host's command and address bytes, and drives MISO from a run-time selectable pattern. It sits in the stimulus tree between the top-level SPI master pins and the bench, and is also usable on-FPGA as a loopback target on the TEST_* pins.

Parameters:
DATA_W, 8, bits per SPI byte, MSB first
CMD_BYTES, 4, header bytes (command + 24-bit address) before the data phase
CNT_W, 16, width of frame byte counter
LFSR_SEED, 16'hACE1, LFSR load value at each frame start (nonzero)

Ports:
CLKA  input  1  system clock; SCK must be ≤ CLKA/4
rst_n  input  1  asynchronous active-low reset
spi_clk  input  1  SCK from master, mode 0 (CPOL=0, CPHA=0)
spi_cs_n  input  1  chip select, active low
spi_mosi  input  1  host data
spi_miso  output  1  generated data
pattern_mode  input  2  0=TOGGLE, 1=COUNT, 2=LFSR, 3=ECHO; sampled at CS fall
cmd_byte  output  DATA_W  first byte of current frame
addr  output  24  bytes 2..4 of frame, MSB first
cmd_valid  output  1  one-cycle pulse when header complete
byte_count  output  CNT_W  full bytes received this frame, saturating
busy  output  1  high while synchronised CS is low
frame_err  output  1  one-cycle pulse on CS rise with partial byte

Behaviour:
- Reset: all outputs 0; FSM IDLE; toggle bit 0; LFSR = LFSR_SEED; echo register 0.
- Inputs pass 2-flop synchronisers; SCK rise/fall detected from synced history. Latency pin-to-action 3 CLKA cycles.
- FSM: IDLE -> HDR on synced CS fall (latch pattern_mode, clear bit counter and byte_count, load LFSR seed). HDR -> DATA after CMD_BYTES*DATA_W rising edges (cmd_valid pulse same cycle as last header bit). HDR/DATA -> IDLE on CS rise.
- MOSI sampled on SCK rise; bit counter wraps 0..DATA_W-1; byte_count increments on wrap, saturates at 2^CNT_W-1.
- MISO updates on SCK fall and at CS fall (first bit ready before first rise).
- TOGGLE: invert on every SCK fall, also in HDR; value persists across frames (legacy-compatible).
- COUNT/LFSR/ECHO: MISO=0 during HDR. COUNT: data byte k outputs k[DATA_W-1:0], wraps 0xFF->0x00. LFSR: x^16+x^14+x^13+x^11 Fibonacci, outputs bit 0, advances once per data bit. ECHO: outputs previous full MOSI byte; first data byte outputs last header byte.
- CS rise mid-byte: partial byte discarded, frame_err pulse, no byte_count increment. CS rise mid-header: no cmd_valid.
- SCK edges while CS high ignored. pattern_mode changes mid-frame ignored.
- Reset mid-frame: immediate return to reset state; next frame needs fresh CS fall.

Optional Feature:
MISO_HIZ_EN: adds output spi_miso_oe (1 bit), high only while busy; spi_miso forced 0 when oe low. Without it: no oe port, spi_miso holds last value between frames.

Decomposition:
Package spi_stim_pkg: pattern_mode_e enum, state_e {IDLE,HDR,DATA}, LFSR tap constant, default seed. Natural sub-module: spi_pin_sync (2-flop sync + edge detect for SCK/CS/MOSI).

Test Plan:
- TOGGLE, 2 frames of 8 SCK cycles -> MISO toggles 16 times across frames, starts 0 after reset.
- COUNT, MOSI 0x03,0x12,0x34,0x56 then 3 data bytes -> cmd_byte=0x03, addr=0x123456, cmd_valid one pulse, MISO bytes 0x00,0x01,0x02, byte_count=7.
- LFSR, header + 2 bytes, repeated -> data identical both frames, first 16 bits match reference LFSR from 0xACE1.
- ECHO, header then MOSI 0xA5,0x3C -> MISO data 0x56,0xA5.
- CS rise after 5 bits of byte 3 -> frame_err pulse, byte_count=2, no cmd_valid; rst_n low mid-frame -> all outputs 0 within same cycle.
